midi_event_encoder: RTL

//  Transmit-side counterpart of the MIDI input decoder. Takes note, controller, program and pitch

---
 rtl/midi_event_encoder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/midi_event_encoder.sv
// rtl/midi_event_encoder.sv - queues synth/panel events and serializes them as MIDI channel-voice bytes
// Optional running status: define MIDI_RUNNING_STATUS_EN.
module midi_event_encoder #(
  parameter int FIFO_AW        = 3,
  parameter int RS_IDLE_CYCLES = 25000
) (
  input  logic               CLOCK_25,
  input  logic               reset_reg,
  input  logic [3:0]         midi_ch,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [2:0]         ev_type,
  input  logic [6:0]         ev_d1,
  input  logic [6:0]         ev_d2,
  input  logic               midi_out_ready,
  output logic               midi_send_byte,
  output logic [7:0]         midi_out_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ev_drop,
  output logic               busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND_ST, WAIT_ST, SEND_D1, WAIT_D1, SEND_D2, WAIT_D2
  } state_t;

  state_t             state;
  logic [16:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               empty;
  logic               push;
  logic               pop;
  logic [2:0]         head_type;
  logic [6:0]         head_d1;
  logic [6:0]         head_d2;
  logic [7:0]         head_status;
  logic               skip_status;
  logic [7:0]         status_r;
  logic [6:0]         d1_r;
  logic [6:0]         d2_r;
  logic               two_bytes;

  function automatic logic [3:0] code_of(input logic [2:0] t);
    case (t)
      3'd0:    code_of = 4'h8;
      3'd1:    code_of = 4'h9;
      3'd2:    code_of = 4'hB;
      3'd3:    code_of = 4'hC;
      default: code_of = 4'hE;
    endcase
  endfunction

  assign empty       = (level == '0);
  assign ev_ready    = (level != FULL_LEVEL);
  assign fifo_level  = level;
  assign busy        = (state != IDLE) || !empty;
  assign push        = ev_valid && ev_ready && (ev_type <= 3'd4);
  assign pop         = (state == LOAD);
  assign {head_type, head_d1, head_d2} = mem[rd_ptr];
  assign head_status = {code_of(head_type), midi_ch};

  // Event FIFO; unsupported types are accepted but never stored.
  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ev_drop <= 1'b0;
    end else begin
      ev_drop <= ev_valid && ev_ready && (ev_type > 3'd4);
      if (push) begin
        mem[wr_ptr] <= {ev_type, ev_d1, ev_d2};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  localparam int RS_W = $clog2(RS_IDLE_CYCLES + 1);

  logic [RS_W-1:0] idle_cnt;
  logic            rs_valid;
  logic [7:0]      last_status;

  assign skip_status = rs_valid && (last_status == head_status);

  // Status strobes are recognised by bit7 of the byte just sent.
  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      idle_cnt    <= '0;
      rs_valid    <= 1'b0;
      last_status <= 8'h00;
    end else begin
      if (midi_send_byte && midi_out_data[7]) begin
        last_status <= midi_out_data;
        rs_valid    <= 1'b1;
      end
      if ((state == IDLE) && empty) begin
        if (idle_cnt == RS_W'(RS_IDLE_CYCLES - 1)) rs_valid <= 1'b0;
        else idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end
`else
  logic unused_rs;
  assign skip_status = 1'b0;
  assign unused_rs   = ^RS_IDLE_CYCLES;
`endif

  // LOAD also fires the first byte when TX is already idle, giving a two-cycle accept-to-strobe path.
  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      state          <= IDLE;
      midi_send_byte <= 1'b0;
      midi_out_data  <= 8'h00;
      status_r       <= 8'h00;
      d1_r           <= 7'h00;
      d2_r           <= 7'h00;
      two_bytes      <= 1'b0;
    end else begin
      midi_send_byte <= 1'b0;
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD: begin
          status_r  <= head_status;
          d1_r      <= head_d1;
          d2_r      <= head_d2;
          two_bytes <= (head_type == 3'd3);
          if (skip_status) begin
            if (midi_out_ready) begin
              midi_send_byte <= 1'b1;
              midi_out_data  <= {1'b0, head_d1};
              state          <= WAIT_D1;
            end else begin
              state <= SEND_D1;
            end
          end else if (midi_out_ready) begin
            midi_send_byte <= 1'b1;
            midi_out_data  <= head_status;
            state          <= WAIT_ST;
          end else begin
            state <= SEND_ST;
          end
        end
        SEND_ST: if (midi_out_ready) begin
          midi_send_byte <= 1'b1;
          midi_out_data  <= status_r;
          state          <= WAIT_ST;
        end
        WAIT_ST: if (!midi_out_ready) state <= SEND_D1;
        SEND_D1: if (midi_out_ready) begin
          midi_send_byte <= 1'b1;
          midi_out_data  <= {1'b0, d1_r};
          state          <= WAIT_D1;
        end
        WAIT_D1: if (!midi_out_ready) begin
          if (two_bytes) state <= empty ? IDLE : LOAD;
          else state <= SEND_D2;
        end
        SEND_D2: if (midi_out_ready) begin
          midi_send_byte <= 1'b1;
          midi_out_data  <= {1'b0, d2_r};
          state          <= WAIT_D2;
        end
        WAIT_D2: if (!midi_out_ready) state <= empty ? IDLE : LOAD;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
